// File: rtl/hsid_lib_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hsid_lib_search_ctrl
// Description : HSI library search sequencer. Loads one measured pixel (band
//               vector, two samples per word) into the measure buffer, then
//               starts the MSE unit once per library entry and keeps the
//               entry with the smallest MSE (ties keep the lower index).
// Ports       : clk, rst (sync, active high)
//               start, band_count, lib_size      - search request (host)
//               meas_valid/meas_data/meas_ready  - measured-word stream
//               buf_we/buf_addr/buf_wdata        - measure buffer write port
//               mse_start/mse_lib_idx            - MSE unit request
//               mse_done/mse_value               - MSE unit result
//               busy, done, error, best_idx, best_mse - status / result
// Options     : `define HSID_MSE_TIMEOUT_EN adds a WAIT_MSE watchdog of
//               TIMEOUT_CYCLES cycles that ends the search with error=1.
// Revision    : 1.0 - initial release
// ============================================================================
module hsid_lib_search_ctrl #(
  parameter int WORD_WIDTH     = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_WIDTH_ACC = 48,
  parameter int LENGTH_BITS    = 10,
  parameter int LIBRARY_SIZE   = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = $clog2(LIBRARY_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LENGTH_BITS-1:0]    band_count,
  input  logic [IDX_W:0]            lib_size,
  input  logic                      meas_valid,
  input  logic [WORD_WIDTH-1:0]     meas_data,
  output logic                      meas_ready,
  output logic                      buf_we,
  output logic [LENGTH_BITS-1:0]    buf_addr,
  output logic [WORD_WIDTH-1:0]     buf_wdata,
  output logic                      mse_start,
  output logic [IDX_W-1:0]          mse_lib_idx,
  input  logic                      mse_done,
  input  logic [DATA_WIDTH_ACC-1:0] mse_value,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [IDX_W-1:0]          best_idx,
  output logic [DATA_WIDTH_ACC-1:0] best_mse
);

  localparam int DATA_PER_WORD = WORD_WIDTH / DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_READ_MEASURE = 3'd1,
    S_COMPUTE_MSE  = 3'd2,
    S_WAIT_MSE     = 3'd3,
    S_COMPARE_MSE  = 3'd4,
    S_DONE         = 3'd5
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [LENGTH_BITS-1:0]    word_cnt;
  logic [LENGTH_BITS-1:0]    last_word;
  logic [IDX_W-1:0]          lib_last;
  logic [DATA_WIDTH_ACC-1:0] cur_mse;
  logic                      accept;
  logic                      set_error;
  logic                      last_entry;
  logic [LENGTH_BITS:0]      words_needed;
  logic [IDX_W:0]            lib_clamped;

  // Odd band counts still occupy a whole final word.
  assign words_needed = ({1'b0, band_count} + (LENGTH_BITS+1)'(DATA_PER_WORD - 1))
                        / (LENGTH_BITS+1)'(DATA_PER_WORD);
  assign lib_clamped  = (lib_size > (IDX_W+1)'(LIBRARY_SIZE)) ? (IDX_W+1)'(LIBRARY_SIZE)
                                                              : lib_size;

`ifdef HSID_MSE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counts cycles spent in WAIT_MSE; zero on every entry.
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT_MSE) tmo_cnt <= '0;
    else                            tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  // Watchdog not built: TIMEOUT_CYCLES only documents the disabled option.
  if (TIMEOUT_CYCLES > 0) begin : g_no_watchdog
  end
`endif

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    set_error  = 1'b0;
    last_entry = (mse_lib_idx == lib_last);
    case (state)
      S_IDLE: begin
        if (start) begin
          if (band_count == '0 || lib_size == '0) begin
            next_state = S_DONE;
            set_error  = 1'b1;
          end else begin
            next_state = S_READ_MEASURE;
          end
        end
      end
      S_READ_MEASURE: begin
        accept = meas_valid && meas_ready;
        if (accept && word_cnt == last_word) next_state = S_COMPUTE_MSE;
      end
      S_COMPUTE_MSE: next_state = S_WAIT_MSE;
      S_WAIT_MSE: begin
        if (mse_done) begin
          next_state = S_COMPARE_MSE;
`ifdef HSID_MSE_TIMEOUT_EN
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          next_state = S_DONE;
          set_error  = 1'b1;
`endif
        end
      end
      S_COMPARE_MSE: next_state = last_entry ? S_DONE : S_COMPUTE_MSE;
      S_DONE:        next_state = S_IDLE;
      default:       next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      meas_ready  <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      mse_start   <= 1'b0;
      mse_lib_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      best_idx    <= '0;
      best_mse    <= '1;
      word_cnt    <= '0;
      last_word   <= '0;
      lib_last    <= '0;
      cur_mse     <= '0;
    end else begin
      state      <= next_state;
      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      busy       <= (next_state != S_IDLE);
      done       <= (next_state == S_DONE);
      meas_ready <= (next_state == S_READ_MEASURE);
      mse_start  <= (next_state == S_COMPUTE_MSE);
      buf_we     <= accept;
      if (accept) begin
        buf_addr  <= word_cnt;
        buf_wdata <= meas_data;
        word_cnt  <= word_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            last_word   <= LENGTH_BITS'(words_needed - 1'b1);
            lib_last    <= IDX_W'(lib_clamped - 1'b1);
            error       <= set_error;
            best_mse    <= '1;
            best_idx    <= '0;
            word_cnt    <= '0;
            mse_lib_idx <= '0;
          end
        end
        S_WAIT_MSE: begin
          if (mse_done)  cur_mse <= mse_value;
          if (set_error) error   <= 1'b1;
        end
        S_COMPARE_MSE: begin
          if (cur_mse < best_mse) begin
            best_mse <= cur_mse;
            best_idx <= mse_lib_idx;
          end
          if (!last_entry) mse_lib_idx <= mse_lib_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hsid_lib_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hsid_lib_search_ctrl
// Description : Directed self-checking bench for hsid_lib_search_ctrl with a
//               behavioural MSE unit and scoreboards for buffer writes and
//               MSE requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hsid_lib_search_ctrl;
  localparam int WW = 32;
  localparam int LB = 10;
  localparam int LS = 256;
  localparam int AW = 48;
  localparam int IW = 8;
`ifdef HSID_MSE_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LB-1:0] band_count = '0;
  logic [IW:0]   lib_size = '0;
  logic          meas_valid = 1'b0;
  logic [WW-1:0] meas_data = '0;
  logic          meas_ready;
  logic          buf_we;
  logic [LB-1:0] buf_addr;
  logic [WW-1:0] buf_wdata;
  logic          mse_start;
  logic [IW-1:0] mse_lib_idx;
  logic          mse_done = 1'b0;
  logic [AW-1:0] mse_value = '0;
  logic          busy, done, error;
  logic [IW-1:0] best_idx;
  logic [AW-1:0] best_mse;

  hsid_lib_search_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .band_count(band_count), .lib_size(lib_size),
    .meas_valid(meas_valid), .meas_data(meas_data), .meas_ready(meas_ready),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .mse_start(mse_start), .mse_lib_idx(mse_lib_idx), .mse_done(mse_done),
    .mse_value(mse_value), .busy(busy), .done(done), .error(error),
    .best_idx(best_idx), .best_mse(best_mse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [LB+WW-1:0] exp_wr[$];
  int               exp_idx[$];
  logic [AW-1:0]    vals[LS];
  int  lat    = 5;
  int  hang   = -1;
  logic inject = 1'b0;
  int  n_wr = 0, n_start = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Buffer write scoreboard.
  always @(negedge clk) begin
    logic [LB+WW-1:0] e;
    if (!rst && buf_we) begin
      n_wr++;
      if (exp_wr.size() == 0) chk("wr_unexpected", 64'(exp_wr.size()), 64'd1);
      else begin
        e = exp_wr.pop_front();
        chk("wr_addr_data", 64'({buf_addr, buf_wdata}), 64'(e));
      end
    end
  end

  // Behavioural MSE unit: answers `lat` cycles after mse_start unless hung.
  int cnt = 0;
  int cur = 0;
  bit pend = 1'b0;
  always @(negedge clk) begin
    mse_done = inject;
    if (rst) pend = 1'b0;
    else if (mse_start) begin
      n_start++;
      if (exp_idx.size() == 0) chk("start_unexpected", 64'(exp_idx.size()), 64'd1);
      else chk("start_idx", 64'(mse_lib_idx), 64'(exp_idx.pop_front()));
      cur = int'(mse_lib_idx);
      if (cur != hang) begin pend = 1'b1; cnt = lat; end
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        mse_done  = 1'b1;
        mse_value = vals[cur];
        pend      = 1'b0;
      end
    end
  end

  // Launches a search, streams the words and waits for done.
  task automatic run(input int bc, input int ls, input bit toggle, input int disturb,
                     input int budget, output int cyc, output int pulses);
    int n_eff, lim, nw, guard;
    logic [WW-1:0] d;
    n_wr = 0; n_start = 0;
    n_eff = (ls > LS) ? LS : ls;
    lim   = (hang >= 0 && hang < n_eff) ? hang + 1 : n_eff;
    if (bc != 0 && ls != 0) for (int i = 0; i < lim; i++) exp_idx.push_back(i);
    step();
    band_count = LB'(bc); lib_size = (IW+1)'(ls); start = 1'b1;
    nw = (bc != 0 && ls != 0) ? (bc + 1) / 2 : 0;
    for (int w = 0; w < nw; w++) begin
      d = $urandom;
      exp_wr.push_back({LB'(w), d});
      guard = 0;
      do begin
        step();
        meas_valid = 1'b1; meas_data = d;
        start  = (w == disturb && guard == 0);
        inject = (w == disturb && guard == 0);
        guard++;
      end while (!meas_ready && guard < 50);
      if (guard >= 50) chk("ready_timeout", 64'(meas_ready), 64'd1);
      if (toggle) begin
        step();
        meas_valid = 1'b0; meas_data = ~d; start = 1'b0; inject = 1'b0;
      end
    end
    pulses = 0; cyc = 0;
    while (pulses == 0 && cyc < budget) begin
      step();
      meas_valid = 1'b0; start = 1'b0; inject = 1'b0;
      cyc++;
      if (done) pulses++;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      if (done) pulses++;
    end
  endtask

  task automatic expect_best(input int n, output int bi, output logic [AW-1:0] bm);
    bm = '1; bi = 0;
    for (int i = 0; i < n; i++) if (vals[i] < bm) begin bm = vals[i]; bi = i; end
  endtask

  task automatic check_run(string t, input int pulses, input int nwr, input int nst,
                           input int n_best, input bit err);
    int bi;
    logic [AW-1:0] bm;
    expect_best(n_best, bi, bm);
    chk({t, "_done_pulses"}, 64'(pulses), 64'd1);
    chk({t, "_writes"}, 64'(n_wr), 64'(nwr));
    chk({t, "_mse_starts"}, 64'(n_start), 64'(nst));
    chk({t, "_error"}, 64'(error), 64'(err));
    chk({t, "_best_idx"}, 64'(best_idx), 64'(bi));
    chk({t, "_best_mse"}, 64'(best_mse), 64'(bm));
    chk({t, "_busy_after"}, 64'(busy), 64'd0);
    chk({t, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    chk({t, "_idx_left"}, 64'(exp_idx.size()), 64'd0);
  endtask

  initial begin
    int cyc, pulses, guard;
    vals[0] = 500; vals[1] = 120; vals[2] = 120; vals[3] = 900;

    // Reset values
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_ready", 64'(meas_ready), 64'd0);
    chk("rst_best_mse", 64'(best_mse), 64'hFFFF_FFFF_FFFF);
    chk("rst_best_idx", 64'(best_idx), 64'd0);

    // Main search: 16 words, 4 entries, tie keeps entry 1
    lat = 5;
    run(32, 4, 1'b0, -1, 200, cyc, pulses);
    check_run("main", pulses, 16, 4, 4, 1'b0);

    // Odd band count with gaps in meas_valid
    vals[0] = 77; vals[1] = 33; lat = 2;
    run(3, 2, 1'b1, -1, 100, cyc, pulses);
    check_run("odd", pulses, 2, 2, 2, 1'b0);

    // Zero band_count / zero lib_size
    run(0, 3, 1'b0, -1, 20, cyc, pulses);
    check_run("zero_bc", pulses, 0, 0, 0, 1'b1);
    chk("zero_bc_latency_ok", 64'(cyc <= 2), 64'd1);
    run(5, 0, 1'b0, -1, 20, cyc, pulses);
    check_run("zero_ls", pulses, 0, 0, 0, 1'b1);
    chk("zero_ls_latency_ok", 64'(cyc <= 2), 64'd1);

    // start while busy and spurious mse_done during READ_MEASURE
    vals[0] = 500; vals[1] = 120; vals[2] = 120; vals[3] = 900; lat = 5;
    run(32, 4, 1'b0, 5, 200, cyc, pulses);
    check_run("disturb", pulses, 16, 4, 4, 1'b0);

    // lib_size above LIBRARY_SIZE is clamped
    for (int i = 0; i < LS; i++) vals[i] = AW'(5000 + ((i * 73 + 100) % 257));
    lat = 1;
    run(2, 300, 1'b0, -1, 3000, cyc, pulses);
    check_run("clamp", pulses, 1, 256, 256, 1'b0);

`ifdef HSID_MSE_TIMEOUT_EN
    // Watchdog: entry 2 never answers
    vals[0] = 500; vals[1] = 120; vals[2] = 120; vals[3] = 900; lat = 3; hang = 2;
    run(4, 4, 1'b0, -1, 300, cyc, pulses);
    check_run("timeout", pulses, 2, 3, 2, 1'b1);
    hang = -1;
`endif

    // Reset while waiting on the MSE unit
    hang = 0;
    exp_idx.push_back(0);
    exp_wr.push_back({LB'(0), 32'hA5A5_0001});
    step();
    band_count = 2; lib_size = 2; start = 1'b1;
    step();
    start = 1'b0; meas_valid = 1'b1; meas_data = 32'hA5A5_0001;
    step();
    meas_valid = 1'b0;
    guard = 0;
    while (!mse_start && guard < 20) begin step(); guard++; end
    chk("rst_mid_start_seen", 64'(mse_start), 64'd1);
    step(); step();
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_best_mse", 64'(best_mse), 64'hFFFF_FFFF_FFFF);
    chk("rst_mid_best_idx", 64'(best_idx), 64'd0);
    hang = -1;
    exp_wr.delete();
    exp_idx.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/hsid_lib_search_ctrl.md
Name: hsid_lib_search_ctrl

Overview:
- Top-level sequencer for HSI library matching: loads one measured pixel (band vector) into the measure buffer, then runs the MSE unit once per library entry and tracks the minimum.
- Sits between the host/bus interface, the measure buffer and the MSE datapath.
- Reports best-matching library index and its MSE.

Parameters:
- WORD_WIDTH, 32, input word width; DATA_PER_WORD = WORD_WIDTH/DATA_WIDTH = 2 samples per word.
- DATA_WIDTH, 16, band sample width.
- DATA_WIDTH_ACC, 48, MSE value width.
- LENGTH_BITS, 10, width of band_count.
- LIBRARY_SIZE, 256, maximum library entries; IDX_W = $clog2(LIBRARY_SIZE).
- TIMEOUT_CYCLES, 1024, MSE watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin search; sampled only in IDLE.
- band_count  in  LENGTH_BITS  bands per pixel; latched on accepted start.
- lib_size  in  IDX_W+1  library entries to scan (1..LIBRARY_SIZE); latched on accepted start.
- meas_valid  in  1  measure word valid.
- meas_data  in  WORD_WIDTH  two packed samples; low half is the lower band.
- meas_ready  out  1  controller accepts a measure word.
- buf_we  out  1  measure buffer write strobe.
- buf_addr  out  LENGTH_BITS  measure buffer word address.
- buf_wdata  out  WORD_WIDTH  measure buffer write data.
- mse_start  out  1  one-cycle pulse to the MSE unit.
- mse_lib_idx  out  IDX_W  library entry under evaluation.
- mse_done  in  1  MSE result valid (one-cycle pulse).
- mse_value  in  DATA_WIDTH_ACC  MSE result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- error  out  1  result invalid; held until next accepted start.
- best_idx  out  IDX_W  index of minimum MSE; held until next accepted start.
- best_mse  out  DATA_WIDTH_ACC  minimum MSE; held until next accepted start.

Behaviour:
- Registered outputs. Reset values: state IDLE; meas_ready, buf_we, mse_start, busy, done, error = 0; buf_addr, buf_wdata, mse_lib_idx, best_idx = 0; best_mse = all ones.
- Reset mid-operation returns to IDLE on the next edge. The in-flight MSE result is discarded.
- States and transitions:
  - IDLE: on start, latch band_count/lib_size, clear error, set best_mse = all ones and best_idx = 0.
    - If band_count==0 or lib_size==0, go to DONE with error=1.
    - Otherwise go to READ_MEASURE.
  - READ_MEASURE: meas_ready=1. Each cycle with meas_valid && meas_ready, buf_we=1 for exactly one cycle, with buf_wdata=meas_data and buf_addr=word counter (from 0); the counter increments.
    - Words needed W = ceil(band_count/2). An odd count still consumes the full last word.
    - After word W-1 is accepted, meas_ready drops the next cycle and the state goes to COMPUTE_MSE with mse_lib_idx=0.
  - COMPUTE_MSE: mse_start=1 for one cycle; go to WAIT_MSE.
  - WAIT_MSE: hold until mse_done. Capture mse_value; go to COMPARE_MSE.
  - COMPARE_MSE: if captured value < best_mse (strict), update best_mse/best_idx.
    - Ties keep the lower index.
    - If mse_lib_idx == lib_size-1, go to DONE. Otherwise increment mse_lib_idx and go to COMPUTE_MSE.
  - DONE: done=1 for one cycle; go to IDLE.
- start outside IDLE is ignored. start asserted in the DONE cycle is not accepted; it is taken only if still high once in IDLE.
- mse_done outside WAIT_MSE is ignored.
- lib_size > LIBRARY_SIZE is clamped to LIBRARY_SIZE.
- Per-entry cost: 3 cycles + MSE latency.

Optional Feature:
- Macro HSID_MSE_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT_MSE, cleared on entry. If it reaches TIMEOUT_CYCLES without mse_done, go to DONE with error=1; best_idx/best_mse keep the entries compared so far.
- Undefined: no counter; WAIT_MSE waits indefinitely; error is set only by zero band_count/lib_size.

Test Plan:
- Reset: rst high 2 cycles during WAIT_MSE -> IDLE; busy=0, done=0, best_mse=all ones, best_idx=0.
- band_count=32, lib_size=4, MSE model returns 500,120,120,900 with latency 5 -> 16 buf_we writes at addr 0..15; four mse_start pulses idx 0..3; done once; best_idx=1 (tie keeps 1), best_mse=120, error=0.
- band_count=3, meas_valid toggling every other cycle -> exactly 2 words written, addr 0 and 1; no write while meas_valid=0.
- band_count=0 or lib_size=0 -> done pulse 2 cycles after start, error=1, no buf_we, no mse_start.
- start pulsed while busy, plus spurious mse_done during READ_MEASURE -> ignored; results match an undisturbed run.
- HSID_MSE_TIMEOUT_EN, TIMEOUT_CYCLES=16, MSE never answers for entry 2 of 4 -> done with error=1 after 16 cycles in WAIT_MSE; best_idx among entries 0..1.
